// File: rtl/count_seq_pkg.sv
// Shared definitions for the count arbiter sequencer and its helpers:
// FSM state encoding, default parameter values and the round-robin
// grant selection used when both requesters ask at the same time.
package count_seq_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] COUNTING = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;

  // Board defaults: 12 MHz clock divided down to an 8 Hz count tick
  localparam int DEF_CLK_DIV = 1500000;
  localparam int DEF_CNT_W   = 4;
  localparam int DEF_LIMIT0  = 15;
  localparam int DEF_LIMIT1  = 7;

  // Returns a one-hot grant for the active requests. A lone request wins
  // outright; on a tie the requester that did not win last time is chosen.
  function automatic logic [1:0] pick_grant(input logic [1:0] reqs,
                                            input logic       last_idx);
    logic [1:0] grant;
    grant = 2'b00;
    unique case (reqs)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_idx ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    return grant;
  endfunction

endpackage

// File: rtl/count_arbiter_seq_if.sv
// Bundle of the request/grant/counter signals between the button front end
// (master) and the count arbiter sequencer (slave).
interface count_arbiter_seq_if
  import count_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic [1:0]       req;
  logic [CNT_W-1:0] count;
  logic [1:0]       gnt;
  logic             busy;
  logic             done;
  logic             tick;

  // Requesting side: drives requests, observes the counter and status
  modport master (
    output req,
    input  count,
    input  gnt,
    input  busy,
    input  done,
    input  tick
  );

  // Sequencer side: receives requests, drives counter and status
  modport slave (
    input  req,
    output count,
    output gnt,
    output busy,
    output done,
    output tick
  );

endinterface

// File: rtl/tick_gen.sv
// Free-running clock-enable generator: one-cycle tick every CLK_DIV clocks.
// Used instead of a derived clock so every LED block stays in the clk domain.
module tick_gen
  import count_seq_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] div_cnt;

  // Divider counts 0..CLK_DIV-1 and wraps, independent of any consumer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  // Tick is decoded from the divider register only
  always_comb begin
    tick = (div_cnt == DIV_LAST);
  end

endmodule

// File: rtl/count_arbiter_seq.sv
// Shares one LED up-counter between two requesters. Start requests are
// arbitrated round-robin in IDLE, the winner's run counts up to its own
// limit on the divided tick, then DONE is shown for one tick period.
// All outputs come from registers or state decode only.
module count_arbiter_seq
  import count_seq_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LIMIT0  = DEF_LIMIT0,
  parameter int LIMIT1  = DEF_LIMIT1
) (
  input  logic                clk,
  input  logic                rst,
  count_arbiter_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] LIM0    = CNT_W'(LIMIT0);
  localparam logic [CNT_W-1:0] LIM1    = CNT_W'(LIMIT1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       gnt_q;
  logic             last;
  logic             tick;
  logic [1:0]       grant_pick;
  logic [CNT_W-1:0] cur_limit;

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Arbitration choice and the terminal count of whoever holds the grant
  always_comb begin
    grant_pick = pick_grant(bus.req, last);
    cur_limit  = gnt_q[1] ? LIM1 : LIM0;
  end

  // Sequencer FSM with counter, grant register and round-robin history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count_q <= '0;
      gnt_q   <= 2'b00;
      last    <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            state   <= COUNTING;
            gnt_q   <= grant_pick;
            count_q <= '0;
            last    <= grant_pick[1];
          end
        end
        COUNTING: begin
          if (tick) begin
            if (count_q == cur_limit) begin
              state <= DONE;
            end else begin
              count_q <= count_q + CNT_ONE;
            end
          end
        end
        DONE: begin
          if (tick) begin
            state   <= IDLE;
            count_q <= '0;
            gnt_q   <= 2'b00;
          end
        end
        default: begin
          state   <= IDLE;
          count_q <= '0;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

  // Moore outputs: registered counter and grant, status from state
  always_comb begin
    bus.count = count_q;
    bus.gnt   = gnt_q;
    bus.busy  = (state == COUNTING) || (state == DONE);
    bus.done  = (state == DONE);
    bus.tick  = tick;
  end

endmodule

// File: tb/tb_count_arbiter_seq.sv
// Randomized scoreboard bench for count_arbiter_seq. The stimulus side
// predicts each run (winner, grant edge, first tick edge, end edge) from
// tick arithmetic and pushes it; the monitor pops runs as the DUT starts
// them and checks every cycle's outputs against the predicted run.
module tb_count_arbiter_seq;

  localparam int TB_DIV = 4;
  localparam int TB_W   = 4;
  localparam int LIM0   = 15;
  localparam int LIM1   = 7;

  typedef struct {
    int idx;
    int grant_edge;
    int t1;
    int end_edge;
    int lim;
  } run_t;

  logic clk;
  logic rst;

  count_arbiter_seq_if #(.CNT_W(TB_W)) bus ();

  count_arbiter_seq #(
    .CLK_DIV (TB_DIV),
    .CNT_W   (TB_W),
    .LIMIT0  (LIM0),
    .LIMIT1  (LIM1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  run_t sb_q[$];

  // reference model state (stimulus side)
  int model_edge = 0;
  bit m_busy     = 0;
  int m_last     = 1;
  int m_end      = 0;
  int m_grants   = 0;

  // monitor state
  int   mon_edge = 0;
  bit   active   = 0;
  run_t cur;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s edge=%0d actual=%0d expected=%0d", name, mon_edge, act, exp);
    end
  endtask

  // Drive req for the coming edge and predict what that edge does
  task automatic apply_stimulus(input logic [1:0] r);
    int   e;
    run_t nr;
    bus.req = r;
    e = model_edge + 1;
    if (m_busy) begin
      if (e == m_end) m_busy = 0;
    end else if (r != 2'b00) begin
      if (r == 2'b11) nr.idx = (m_last == 0) ? 1 : 0;
      else            nr.idx = r[1] ? 1 : 0;
      nr.lim        = (nr.idx == 0) ? LIM0 : LIM1;
      nr.grant_edge = e;
      nr.t1         = (e / TB_DIV + 1) * TB_DIV;
      nr.end_edge   = nr.t1 + TB_DIV * (nr.lim + 1);
      sb_q.push_back(nr);
      m_busy   = 1;
      m_end    = nr.end_edge;
      m_last   = nr.idx;
      m_grants++;
    end
    model_edge = e;
    @(negedge clk);
  endtask

  task automatic model_clear();
    model_edge = 0;
    m_busy     = 0;
    m_last     = 1;
    sb_q.delete();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && m_busy; i++) apply_stimulus(2'b00);
    repeat (3) apply_stimulus(2'b00);
  endtask

  task automatic hold_until_grants(input logic [1:0] r, input int n);
    int target;
    target = m_grants + n;
    for (int i = 0; i < 600 && m_grants < target; i++) apply_stimulus(r);
  endtask

  // Monitor: sample just after each active edge and score the outputs
  always @(posedge clk) begin
    int j;
    int exp_count;
    int exp_done;
    #1;
    if (rst) begin
      mon_edge = 0;
      active   = 0;
    end else begin
      mon_edge++;
      check_output("tick", int'(bus.tick), int'((mon_edge % TB_DIV) == TB_DIV - 1));
      if (!active && bus.busy) begin
        if (sb_q.size() == 0) begin
          check_output("pending_runs", sb_q.size(), 1);
        end else begin
          cur    = sb_q.pop_front();
          active = 1;
          check_output("grant_edge", mon_edge, cur.grant_edge);
          check_output("grant_idx", int'(bus.gnt), 1 << cur.idx);
        end
      end
      if (active) begin
        if (mon_edge >= cur.end_edge) begin
          check_output("end_busy", int'(bus.busy), 0);
          check_output("end_count", int'(bus.count), 0);
          check_output("end_gnt", int'(bus.gnt), 0);
          check_output("end_done", int'(bus.done), 0);
          active = 0;
        end else begin
          j         = (mon_edge < cur.t1) ? 0 : (mon_edge - cur.t1) / TB_DIV + 1;
          exp_count = (j > cur.lim) ? cur.lim : j;
          exp_done  = (j >= cur.lim + 1) ? 1 : 0;
          check_output("run_busy", int'(bus.busy), 1);
          check_output("run_gnt", int'(bus.gnt), 1 << cur.idx);
          check_output("run_count", int'(bus.count), exp_count);
          check_output("run_done", int'(bus.done), exp_done);
        end
      end else if (!bus.busy) begin
        check_output("idle_count", int'(bus.count), 0);
        check_output("idle_gnt", int'(bus.gnt), 0);
        check_output("idle_done", int'(bus.done), 0);
        if (sb_q.size() > 0 && sb_q[0].grant_edge < mon_edge) begin
          check_output("grant_missing_edge", mon_edge, sb_q[0].grant_edge);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  // Stimulus: directed scenarios, random traffic, then a mid-run reset
  initial begin
    int   seg_len;
    logic [1:0] r;
    int   waited;
    rst     = 1'b1;
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();

    $display("[TB] idle after reset");
    repeat (12) apply_stimulus(2'b00);

    $display("[TB] single pulse from requester 0");
    apply_stimulus(2'b01);
    drain();

    $display("[TB] requester 1 held for two runs");
    hold_until_grants(2'b10, 2);
    drain();

    $display("[TB] both held from reset");
    do_reset();
    hold_until_grants(2'b11, 3);
    drain();

    $display("[TB] requester 1 joins during requester 0 run");
    apply_stimulus(2'b01);
    repeat (10) apply_stimulus(2'b01);
    hold_until_grants(2'b11, 1);
    drain();

    $display("[TB] random traffic");
    for (int s = 0; s < 40; s++) begin
      r       = 2'($urandom_range(0, 3));
      seg_len = $urandom_range(1, 30);
      for (int k = 0; k < seg_len; k++) apply_stimulus(r);
    end
    drain();

    $display("[TB] reset in the middle of a run");
    apply_stimulus(2'b01);
    waited = 0;
    while (bus.count != 4'd5 && waited < 200) begin
      apply_stimulus(2'b00);
      waited++;
    end
    check_output("wait_count5", int'(bus.count), 5);
    #1 rst = 1'b1;
    #1;
    check_output("rst_count", int'(bus.count), 0);
    check_output("rst_gnt", int'(bus.gnt), 0);
    check_output("rst_busy", int'(bus.busy), 0);
    check_output("rst_done", int'(bus.done), 0);
    check_output("rst_tick", int'(bus.tick), 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    hold_until_grants(2'b11, 1);
    repeat (5) apply_stimulus(2'b11);
    drain();

    check_output("runs_left", sb_q.size(), 0);
    check_output("run_open", int'(active), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
